// File: rtl/i2s_transmit_pkg.sv
// Shared types for the I2S transmitter: the outcome of opening a slot.
package i2s_transmit_pkg;

  typedef enum logic [1:0] {
    SLOT_LOAD,
    SLOT_MISALIGN,
    SLOT_UNDERRUN
  } slot_e;

  // Decides what a slot of channel 'ws' does with the holding register.
  function automatic slot_e slot_outcome(input logic held, input logic last, input logic ws);
    if (!held)      return SLOT_UNDERRUN;
    if (last != ws) return SLOT_MISALIGN;
    return SLOT_LOAD;
  endfunction

endpackage

// File: rtl/i2s_transmit_sck_gen.sv
// Bit-clock divider: sck toggles every SCK_DIV cycles; fall_o flags the
// cycle whose closing edge drives sck from 1 to 0.
module i2s_sck_gen #(
  parameter int unsigned SCK_DIV = 4
) (
  input  logic clk_i,
  input  logic rst_i,
  output logic sck_o,
  output logic fall_o
);

  localparam int unsigned CW = $clog2(SCK_DIV);
  localparam logic [CW-1:0] CNT_LAST = CW'(SCK_DIV - 1);

  logic [CW-1:0] cnt_q, cnt_d;
  logic          sck_q, sck_d;
  logic          term;

  assign term = (cnt_q == CNT_LAST);

  always_comb begin
    cnt_d = cnt_q + CW'(1);
    sck_d = sck_q;
    if (term) begin
      cnt_d = '0;
      sck_d = ~sck_q;
    end
  end

  always_ff @(posedge clk_i or posedge rst_i) begin
    if (rst_i) begin
      cnt_q <= '0;
      sck_q <= 1'b0;
    end else begin
      cnt_q <= cnt_d;
      sck_q <= sck_d;
    end
  end

  assign sck_o  = sck_q;
  assign fall_o = term & sck_q;

endmodule

// File: rtl/i2s_transmit.sv
// AXI-Stream to I2S transmitter: one-word holding register feeding an MSB-first
// shift register; ws/sd only move on sck falling edges.
module i2s_transmit
  import i2s_transmit_pkg::*;
#(
  parameter int unsigned DATA_WIDTH = 32,
  parameter int unsigned SCK_DIV    = 4
) (
  input  logic                  S_AXIS_ACLK,
  input  logic                  S_AXIS_ARESET,
  input  logic                  S_AXIS_TVALID,
  output logic                  S_AXIS_TREADY,
  input  logic [DATA_WIDTH-1:0] S_AXIS_TDATA,
  input  logic                  S_AXIS_TLAST,
  output logic                  sck,
  output logic                  ws,
  output logic                  sd,
  output logic                  underrun,
  output logic                  misalign
);

  localparam int unsigned BCW = (DATA_WIDTH > 1) ? $clog2(DATA_WIDTH) : 1;
  localparam logic [BCW-1:0] BIT_LAST = BCW'(DATA_WIDTH - 1);

  logic                  fall;
  logic                  hold_valid_q, hold_valid_d;
  logic [DATA_WIDTH-1:0] hold_data_q, hold_data_d;
  logic                  hold_last_q, hold_last_d;
  logic                  tready_q, tready_d;
  logic                  ws_q, ws_d;
  logic                  sd_q, sd_d;
  logic [DATA_WIDTH-1:0] shift_q, shift_d;
  logic [BCW-1:0]        bit_cnt_q, bit_cnt_d;
  logic                  underrun_q, underrun_d;
  logic                  misalign_q, misalign_d;
  slot_e                 slot;

  i2s_sck_gen #(.SCK_DIV(SCK_DIV)) u_sck_gen (
    .clk_i  (S_AXIS_ACLK),
    .rst_i  (S_AXIS_ARESET),
    .sck_o  (sck),
    .fall_o (fall)
  );

  assign slot = slot_outcome(hold_valid_q, hold_last_q, ws_q);

  always_comb begin
    hold_valid_d = hold_valid_q;
    hold_data_d  = hold_data_q;
    hold_last_d  = hold_last_q;
    ws_d         = ws_q;
    sd_d         = sd_q;
    shift_d      = shift_q;
    bit_cnt_d    = bit_cnt_q;
    underrun_d   = 1'b0;
    misalign_d   = 1'b0;

    if (fall) begin
      bit_cnt_d = (bit_cnt_q == BIT_LAST) ? '0 : bit_cnt_q + BCW'(1);
      // The LSB leaves together with the ws toggle, one bit ahead of the next MSB.
      if (bit_cnt_q == BIT_LAST) ws_d = ~ws_q;
      if (bit_cnt_q == '0) begin
        unique case (slot)
          SLOT_LOAD: begin
            sd_d         = hold_data_q[DATA_WIDTH-1];
            shift_d      = {hold_data_q[DATA_WIDTH-2:0], 1'b0};
            hold_valid_d = 1'b0;
          end
          SLOT_MISALIGN: begin
            sd_d       = 1'b0;
            shift_d    = '0;
            misalign_d = 1'b1;
          end
          default: begin
            sd_d       = 1'b0;
            shift_d    = '0;
            underrun_d = 1'b1;
          end
        endcase
      end else begin
        sd_d    = shift_q[DATA_WIDTH-1];
        shift_d = {shift_q[DATA_WIDTH-2:0], 1'b0};
      end
    end

    // tready_q is low whenever a word is held, so this never collides with a load.
    if (S_AXIS_TVALID && tready_q) begin
      hold_valid_d = 1'b1;
      hold_data_d  = S_AXIS_TDATA;
      hold_last_d  = S_AXIS_TLAST;
    end

    tready_d = ~hold_valid_d;
  end

  always_ff @(posedge S_AXIS_ACLK or posedge S_AXIS_ARESET) begin
    if (S_AXIS_ARESET) begin
      hold_valid_q <= 1'b0;
      hold_data_q  <= '0;
      hold_last_q  <= 1'b0;
      tready_q     <= 1'b0;
      ws_q         <= 1'b1;
      sd_q         <= 1'b0;
      shift_q      <= '0;
      bit_cnt_q    <= BIT_LAST;
      underrun_q   <= 1'b0;
      misalign_q   <= 1'b0;
    end else begin
      hold_valid_q <= hold_valid_d;
      hold_data_q  <= hold_data_d;
      hold_last_q  <= hold_last_d;
      tready_q     <= tready_d;
      ws_q         <= ws_d;
      sd_q         <= sd_d;
      shift_q      <= shift_d;
      bit_cnt_q    <= bit_cnt_d;
      underrun_q   <= underrun_d;
      misalign_q   <= misalign_d;
    end
  end

  assign S_AXIS_TREADY = tready_q;
  assign ws            = ws_q;
  assign sd            = sd_q;
  assign underrun      = underrun_q;
  assign misalign      = misalign_q;

endmodule

// File: tb/tb_i2s_transmit.sv
// Bench for i2s_transmit: an I2S receiver model rebuilds slots from sck/ws/sd
// and compares them with a slot-level prediction of the word stream.
module tb_i2s_transmit;

  localparam int DW = 8;
  localparam int SD = 2;

  logic clk = 1'b0;
  always #5 clk = ~clk;

  logic          rst = 1'b1, tvalid = 1'b0, tlast = 1'b0;
  logic [DW-1:0] tdata = '0;
  logic          tready, sck, ws, sd, underrun, misalign;

  logic          rst2 = 1'b1, tvalid2 = 1'b0, tlast2 = 1'b0;
  logic [31:0]   tdata2 = '0;
  logic          tready2, sck2, ws2, sd2, und2, mis2;

  i2s_transmit #(.DATA_WIDTH(DW), .SCK_DIV(SD)) dut (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst), .S_AXIS_TVALID(tvalid),
    .S_AXIS_TREADY(tready), .S_AXIS_TDATA(tdata), .S_AXIS_TLAST(tlast),
    .sck(sck), .ws(ws), .sd(sd), .underrun(underrun), .misalign(misalign));

  i2s_transmit #(.DATA_WIDTH(32), .SCK_DIV(4)) dut_wide (
    .S_AXIS_ACLK(clk), .S_AXIS_ARESET(rst2), .S_AXIS_TVALID(tvalid2),
    .S_AXIS_TREADY(tready2), .S_AXIS_TDATA(tdata2), .S_AXIS_TLAST(tlast2),
    .sck(sck2), .ws(ws2), .sd(sd2), .underrun(und2), .misalign(mis2));

  typedef struct packed {
    logic          ch;
    logic [DW-1:0] data;
    logic [7:0]    nu;
    logic [7:0]    nm;
  } slot_t;
  typedef struct {
    logic [DW-1:0] data;
    logic          last;
  } word_t;

  int    checks = 0, errors = 0;
  word_t tx_q[$];
  slot_t rx_q[$], exp_q[$];
  bit    abort = 1'b0;

  // receiver model state
  bit            mon_on = 1'b0, coll, ws_prev, rdy_seen;
  logic [DW-1:0] sr;
  int            nbits, nu_acc, nm_acc, cyc = 0, last_rise;
  int            edge_err, rise_err, len_err, period_err;
  logic          sck_p, ws_p, sd_p, trdy_p;

  always @(negedge clk) begin
    cyc++;
    if (mon_on) begin
      if ((ws !== ws_p || sd !== sd_p) && !(sck_p && !sck)) edge_err++;
      if (tready && !trdy_p) begin
        if (rdy_seen && !(sck_p && !sck)) rise_err++;
        rdy_seen = 1'b1;
      end
      nu_acc += int'(underrun);
      nm_acc += int'(misalign);
      if (sck && !sck_p) begin
        if (last_rise >= 0 && cyc - last_rise != 2*SD) period_err++;
        last_rise = cyc;
        if (ws !== ws_prev) begin
          if (coll) begin
            if (nbits != DW-1) len_err++;
            rx_q.push_back('{ws_prev, {sr[DW-2:0], sd}, 8'(nu_acc), 8'(nm_acc)});
          end
          coll = 1'b1; sr = '0; nbits = 0; nu_acc = 0; nm_acc = 0; ws_prev = ws;
        end else begin
          sr = {sr[DW-2:0], sd};
          nbits++;
        end
      end
    end
    sck_p = sck; ws_p = ws; sd_p = sd; trdy_p = tready;
  end

  task automatic mon_reset();
    mon_on = 1'b0; coll = 1'b0; ws_prev = 1'b1; rdy_seen = 1'b0; sr = '0;
    nbits = 0; nu_acc = 0; nm_acc = 0; last_rise = -1;
    edge_err = 0; rise_err = 0; len_err = 0; period_err = 0;
    sck_p = 1'b0; ws_p = 1'b1; sd_p = 1'b0; trdy_p = 1'b0;
    rx_q.delete();
    mon_on = 1'b1;
  endtask

  // Leaves rst low right at a negedge.
  task automatic do_reset();
    mon_on = 1'b0;
    @(negedge clk);
    tvalid = 1'b0;
    rst = 1'b1;
    repeat (3) @(negedge clk);
    mon_reset();
    rst = 1'b0;
  endtask

  // Slot-level prediction: channels alternate from left; each slot takes the
  // oldest unsent word if its channel matches, else sends zeros.
  function automatic void build_exp(input int n);
    int hi = 0;
    exp_q.delete();
    for (int k = 0; k < n; k++) begin
      slot_t s;
      s.ch = 1'(k % 2); s.data = '0; s.nu = 8'd0; s.nm = 8'd0;
      if (hi >= tx_q.size())               s.nu = 8'd1;
      else if (tx_q[hi].last !== s.ch)     s.nm = 8'd1;
      else begin s.data = tx_q[hi].data; hi++; end
      exp_q.push_back(s);
    end
  endfunction

  // Called at a negedge; offers each word until accepted.
  task automatic drive_words(input bit garbage);
    int g;
    foreach (tx_q[i]) begin
      g = 0;
      tvalid = 1'b1;
      while (!tready) begin
        if (garbage) begin tdata = DW'($urandom); tlast = 1'($urandom); end
        else begin tdata = tx_q[i].data; tlast = tx_q[i].last; end
        @(negedge clk);
        g++;
        if (abort) begin tvalid = 1'b0; return; end
        if (g > 4000) begin
          checks++; errors++;
          $display("FAIL drive_timeout word %0d: tready=%b, expected 1", i, tready);
          tvalid = 1'b0;
          return;
        end
      end
      tdata = tx_q[i].data; tlast = tx_q[i].last;
      @(negedge clk);
      checks++;
      if (tready !== 1'b0) begin
        errors++;
        $display("FAIL tready_after_xfer word %0d: got %b, expected 0", i, tready);
      end
    end
    tvalid = 1'b0;
  endtask

  task automatic wait_slots(input int n);
    int g = 0;
    while (rx_q.size() < n) begin
      @(negedge clk);
      g++;
      if (g > n * 200) begin
        checks++; errors++;
        $display("FAIL slot_timeout: got %0d slots, expected %0d", rx_q.size(), n);
        return;
      end
    end
  endtask

  task automatic test_reset();
    repeat (3) @(negedge clk);
    #1;
    checks++; if (sck !== 1'b0)      begin errors++; $display("FAIL rst_sck: got %b, expected 0", sck); end
    checks++; if (ws !== 1'b1)       begin errors++; $display("FAIL rst_ws: got %b, expected 1", ws); end
    checks++; if (sd !== 1'b0)       begin errors++; $display("FAIL rst_sd: got %b, expected 0", sd); end
    checks++; if (underrun !== 1'b0) begin errors++; $display("FAIL rst_underrun: got %b, expected 0", underrun); end
    checks++; if (misalign !== 1'b0) begin errors++; $display("FAIL rst_misalign: got %b, expected 0", misalign); end
    checks++; if (tready !== 1'b0)   begin errors++; $display("FAIL rst_tready: got %b, expected 0", tready); end
    @(negedge clk);
    mon_reset();
    rst = 1'b0;
    @(negedge clk);
    checks++; if (tready !== 1'b1)   begin errors++; $display("FAIL tready_after_release: got %b, expected 1", tready); end
  endtask

  task automatic test_idle();
    do_reset();
    tx_q.delete();
    build_exp(6);
    wait_slots(6);
    for (int k = 0; k < 6; k++) begin
      checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL idle slot %0d: got %h, expected %h (ch,data,und,mis)", k,
                 (k < rx_q.size()) ? rx_q[k] : '0, exp_q[k]);
      end
    end
    checks++;
    if (edge_err || rise_err || len_err || period_err) begin
      errors++;
      $display("FAIL idle_timing: edge=%0d rise=%0d len=%0d period=%0d, expected all 0",
               edge_err, rise_err, len_err, period_err);
    end
  endtask

  task automatic run_stream(input string name, input int nslots, input bit garbage);
    do_reset();
    build_exp(nslots);
    fork
      drive_words(garbage);
      wait_slots(nslots);
    join
    for (int k = 0; k < nslots; k++) begin
      checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL %s slot %0d: got %h, expected %h (ch,data,und,mis)", name, k,
                 (k < rx_q.size()) ? rx_q[k] : '0, exp_q[k]);
      end
    end
    checks++;
    if (edge_err || rise_err || len_err || period_err) begin
      errors++;
      $display("FAIL %s_timing: edge=%0d rise=%0d len=%0d period=%0d, expected all 0",
               name, edge_err, rise_err, len_err, period_err);
    end
  endtask

  task automatic test_basic();
    tx_q.delete();
    tx_q.push_back('{8'hA5, 1'b0});
    tx_q.push_back('{8'h3C, 1'b1});
    run_stream("basic", 4, 1'b0);
  endtask

  task automatic test_back_to_back();
    tx_q.delete();
    for (int i = 0; i < 4; i++) tx_q.push_back('{DW'($urandom), 1'(i % 2)});
    run_stream("b2b", 6, 1'b1);
  endtask

  task automatic test_misalign();
    tx_q.delete();
    tx_q.push_back('{8'h5A, 1'b1});
    tx_q.push_back('{8'hC3, 1'b0});
    tx_q.push_back('{8'h77, 1'b1});
    run_stream("misalign", 5, 1'b0);
  endtask

  task automatic test_random();
    tx_q.delete();
    for (int i = 0; i < 16; i++) begin
      logic l;
      l = 1'(i % 2);
      if ($urandom_range(0, 4) == 0) l = ~l;
      tx_q.push_back('{DW'($urandom), l});
    end
    run_stream("random", 34, 1'b1);
  endtask

  task automatic test_reset_mid();
    logic sp, wp;
    int   falls, g;
    bool_wait: begin end
    tx_q.delete();
    for (int i = 0; i < 6; i++) tx_q.push_back('{DW'($urandom), 1'(i % 2)});
    do_reset();
    abort = 1'b0;
    fork
      drive_words(1'b0);
      begin
        sp = sck; wp = ws; falls = -1; g = 0;
        while (falls < 5 && g < 2000) begin
          @(negedge clk);
          g++;
          if (sp && !sck) begin
            if (falls < 0 && !wp && ws) falls = 0;
            else if (falls >= 0) falls++;
          end
          sp = sck; wp = ws;
        end
        checks++;
        if (falls < 5) begin
          errors++;
          $display("FAIL reset_mid_reach: got %0d falls into right word, expected 5", falls);
        end
        mon_on = 1'b0;
        #2 rst = 1'b1;
        abort = 1'b1;
        #1;
        checks++;
        if ({sck, ws, sd, underrun, misalign, tready} !== 6'b010000) begin
          errors++;
          $display("FAIL reset_mid_async: got sck,ws,sd,und,mis,rdy=%b, expected 010000",
                   {sck, ws, sd, underrun, misalign, tready});
        end
      end
    join
    abort = 1'b0;
    tvalid = 1'b0;
    repeat (2) @(negedge clk);
    mon_reset();
    rst = 1'b0;
    tx_q.delete();
    build_exp(4);
    wait_slots(4);
    for (int k = 0; k < 4; k++) begin
      checks++;
      if (k >= rx_q.size() || rx_q[k] !== exp_q[k]) begin
        errors++;
        $display("FAIL reset_mid slot %0d: got %h, expected %h (ch,data,und,mis)", k,
                 (k < rx_q.size()) ? rx_q[k] : '0, exp_q[k]);
      end
    end
  endtask

  task automatic test_wide();
    logic sp, wp;
    int   f, g, ones, pulses;
    logic msb, lsb, ws_at_lsb, ws_first;
    @(negedge clk);
    rst2 = 1'b0;
    g = 0;
    while (!tready2 && g < 20) begin @(negedge clk); g++; end
    tvalid2 = 1'b1; tdata2 = 32'h8000_0001; tlast2 = 1'b0;
    @(negedge clk);
    tvalid2 = 1'b0; tdata2 = 32'hFFFF_FFFF;
    sp = sck2; wp = ws2; f = 0; g = 0; ones = 0; pulses = 0;
    msb = 1'b0; lsb = 1'b0; ws_at_lsb = 1'b0; ws_first = 1'b1;
    while (f < 33 && g < 3000) begin
      @(negedge clk);
      g++;
      pulses += int'(und2) + int'(mis2);
      if (sp && !sck2) begin
        f++;
        if (f == 1) ws_first = ws2;
        else if (f == 2) msb = sd2;
        else if (f < 33) ones += int'(sd2);
        else begin lsb = sd2; ws_at_lsb = ws2 & ~wp; end
      end
      sp = sck2; wp = ws2;
    end
    checks++; if (f != 33)          begin errors++; $display("FAIL wide_falls: got %0d, expected 33", f); end
    checks++; if (ws_first !== 1'b0) begin errors++; $display("FAIL wide_first_ws: got %b, expected 0", ws_first); end
    checks++; if (msb !== 1'b1)     begin errors++; $display("FAIL wide_msb: got %b, expected 1", msb); end
    checks++; if (ones != 0)        begin errors++; $display("FAIL wide_middle: got %0d ones, expected 0", ones); end
    checks++; if (lsb !== 1'b1)     begin errors++; $display("FAIL wide_lsb: got %b, expected 1", lsb); end
    checks++; if (ws_at_lsb !== 1'b1) begin errors++; $display("FAIL wide_ws_toggle_at_lsb: got %b, expected 1", ws_at_lsb); end
    checks++; if (pulses != 0)      begin errors++; $display("FAIL wide_pulses: got %0d, expected 0", pulses); end
  endtask

  initial begin
    #600000;
    $display("FAIL watchdog: simulation time limit reached, expected completion");
    $fatal(1, "watchdog");
  end

  initial begin
    test_reset();
    test_idle();
    test_basic();
    test_back_to_back();
    test_misalign();
    test_random();
    test_reset_mid();
    test_wide();
    $display("Simulation finished: %0d checks, %0d errors", checks, errors);
    $finish;
  end

endmodule
